// File: rtl/log_fifo_apb_reader.sv
`timescale 1ns/1ps
// Firmware log drain: characters pushed by the log source are held in a RAM FIFO
// and popped by the host, one per APB read of DATA (fixed one-wait-state slave).
module log_fifo_apb_reader #(
  parameter int DEPTH  = 1024,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int ADDR_W = 12
) (
  input  logic              core_clk,
  input  logic              core_rst,
  input  logic [7:0]        fifo_char,
  input  logic              fifo_write_en,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              log_avail
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [1:0]       REG_DATA = 2'd0;
  localparam logic [1:0]       REG_STAT = 2'd1;
  localparam logic [1:0]       REG_CTRL = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e           state_q, state_d;
  logic             setup;

  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       ram_q;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             avail_q;

  logic [1:0]       idx_q;
  logic             hi_zero_q, wr_q, wclr_q, wflush_q, valid_q;

  logic [31:0]      prdata_q, rdata;
  logic             pready_q, pslverr_q;
  logic             acc_err, commit, pop, flush, w1c, full, push, ovf_set;
  logic             unused_bits;

  function automatic logic [31:0] status_word(input logic [PTR_W:0] cnt, input logic ovf);
    return {16'(cnt), 13'd0, ovf, cnt == FULL_CNT, cnt == '0};
  endfunction

  assign unused_bits = ^{PADDR[1:0], PWDATA[31:3], PWDATA[1]};

  always_ff @(posedge core_clk) begin
    if (core_rst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    setup   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          setup   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Setup edge: capture the request and the head of the FIFO
  always_ff @(posedge core_clk) begin
    if (setup) begin
      idx_q     <= PADDR[3:2];
      hi_zero_q <= (PADDR[ADDR_W-1:4] == '0);
      wr_q      <= PWRITE;
      wclr_q    <= PWDATA[2];
      wflush_q  <= PWDATA[0];
      valid_q   <= (count_q != '0);
      ram_q     <= mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge core_clk) begin
    if (push) mem_q[wr_ptr_q] <= fifo_char;
  end

  always_comb begin
    acc_err = !hi_zero_q || (idx_q == 2'd3) || (wr_q && idx_q == REG_DATA);
    rdata   = '0;
    if (!acc_err && !wr_q) begin
      case (idx_q)
        REG_DATA: rdata = {23'd0, valid_q, valid_q ? ram_q : 8'h00};
        REG_STAT: rdata = status_word(count_q, ovf_q);
        default:  rdata = '0;
      endcase
    end
  end

  // Wait state: register the response so it is presented during RESP only
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q  <= (state_q == S_WAIT);
      prdata_q  <= (state_q == S_WAIT) ? rdata : '0;
      pslverr_q <= (state_q == S_WAIT) && acc_err;
    end
  end

  // Response edge: side effects commit; flush overrides any same-cycle push
  always_comb begin
    commit   = (state_q == S_RESP) && !acc_err;
    pop      = commit && !wr_q && (idx_q == REG_DATA) && valid_q;
    flush    = commit && wr_q && (idx_q == REG_CTRL) && wflush_q;
    w1c      = commit && wr_q && (idx_q == REG_STAT) && wclr_q;
    full     = (count_q == FULL_CNT);
    push     = fifo_write_en && !flush && (!full || pop);
    ovf_set  = fifo_write_en && !flush && full && !pop;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
    end
    if (ovf_set)  ovf_d = 1'b1;
    else if (w1c) ovf_d = 1'b0;
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      avail_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      avail_q  <= (count_d != '0);
    end
  end

  assign PRDATA    = prdata_q;
  assign PREADY    = pready_q;
  assign PSLVERR   = pslverr_q;
  assign log_avail = avail_q;

endmodule

// File: tb/tb_log_fifo_apb_reader.sv
`timescale 1ns/1ps
// Directed bench for log_fifo_apb_reader: a vector table for single transfers
// plus hand-written sequences for overflow, full/pop/push, flush and reset corners.
module tb_log_fifo_apb_reader;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              core_rst;
  logic [7:0]        fifo_char;
  logic              fifo_write_en;
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL, PENABLE, PWRITE;
  logic [31:0]       PWDATA, PRDATA;
  logic              PREADY, PSLVERR, log_avail;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  log_fifo_apb_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .core_clk(clk), .core_rst(core_rst),
    .fifo_char(fifo_char), .fifo_write_en(fifo_write_en),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .log_avail(log_avail)
  );

  typedef struct {
    logic        do_push;
    logic [7:0]  ch;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        exp_avail;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic p, input logic [7:0] c, input logic w,
                              input logic [11:0] a, input logic [31:0] wd,
                              input logic [31:0] er, input logic ee, input logic ea);
    vec_t v;
    v.do_push = p; v.ch = c; v.wr = w; v.addr = a; v.wdata = wd;
    v.exp_rd = er; v.exp_err = ee; v.exp_avail = ea;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic push1(input logic [7:0] c);
    @(posedge clk); #1;
    fifo_char = c; fifo_write_en = 1'b1;
    @(posedge clk); #1;
    fifo_write_en = 1'b0;
  endtask

  task automatic push_seq(input int n);
    @(posedge clk); #1;
    fifo_write_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      fifo_char = 8'(i);
      @(posedge clk); #1;
    end
    fifo_write_en = 1'b0;
  endtask

  // pp selects a push in the setup (1), wait (2) or response (3) cycle
  task automatic xfer(input string nm, input logic wr, input logic [11:0] addr,
                      input logic [31:0] wd, input int pp, input logic [7:0] pch,
                      input logic [31:0] exp_rd, input logic exp_err);
    int          n;
    logic [31:0] rd;
    logic        err;
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wd;
    fifo_char = pch; fifo_write_en = (pp == 1);
    @(posedge clk); #1;
    PENABLE = 1'b1; fifo_write_en = (pp == 2);
    chk({nm, " wait-phase"}, PRDATA | {30'd0, PREADY, PSLVERR}, 32'd0);
    n = 0;
    while (!PREADY && n < 8) begin
      @(posedge clk); #1;
      fifo_write_en = 1'b0;
      n++;
    end
    fifo_write_en = (pp == 3);
    rd  = PRDATA;
    err = PSLVERR;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; fifo_write_en = 1'b0;
    chk({nm, " latency"}, 32'(n), 32'd1);
    chk({nm, " prdata"}, rd, exp_rd);
    chk({nm, " pslverr"}, {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: no finish by time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int highs;
    core_rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0;
    PWDATA = '0; fifo_char = '0; fifo_write_en = 1'b0;

    //               push  ch     wr    addr     wdata  exp_rd         err   avail
    vecs[0]  = mk(1'b0, 8'h00, 1'b0, 12'h004, 32'h0, 32'h0000_0001, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 8'h48, 1'b0, 12'h004, 32'h0, 32'h0001_0000, 1'b0, 1'b1);
    vecs[2]  = mk(1'b1, 8'h69, 1'b0, 12'h000, 32'h0, 32'h0000_0148, 1'b0, 1'b1);
    vecs[3]  = mk(1'b0, 8'h00, 1'b0, 12'h000, 32'h0, 32'h0000_0169, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 8'h00, 1'b0, 12'h000, 32'h0, 32'h0000_0000, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 8'h00, 1'b0, 12'h004, 32'h0, 32'h0000_0001, 1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 8'h33, 1'b1, 12'h000, 32'h55, 32'h0,        1'b1, 1'b1);
    vecs[7]  = mk(1'b0, 8'h00, 1'b0, 12'h004, 32'h0, 32'h0001_0000, 1'b0, 1'b1);
    vecs[8]  = mk(1'b0, 8'h00, 1'b0, 12'h010, 32'h0, 32'h0,         1'b1, 1'b1);
    vecs[9]  = mk(1'b0, 8'h00, 1'b0, 12'h00C, 32'h0, 32'h0,         1'b1, 1'b1);
    vecs[10] = mk(1'b0, 8'h00, 1'b0, 12'h008, 32'h0, 32'h0,         1'b0, 1'b1);
    vecs[11] = mk(1'b0, 8'h00, 1'b1, 12'h808, 32'h1, 32'h0,         1'b1, 1'b1);
    vecs[12] = mk(1'b0, 8'h00, 1'b0, 12'h004, 32'h0, 32'h0001_0000, 1'b0, 1'b1);
    vecs[13] = mk(1'b0, 8'h00, 1'b1, 12'h008, 32'h1, 32'h0,         1'b0, 1'b0);
    vecs[14] = mk(1'b0, 8'h00, 1'b0, 12'h004, 32'h0, 32'h0000_0001, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1 core_rst = 1'b0;
    chk("reset outputs", PRDATA | {29'd0, PREADY, PSLVERR, log_avail}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].do_push) push1(vecs[i].ch);
      xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, 8'h00,
           vecs[i].exp_rd, vecs[i].exp_err);
      chk($sformatf("vec%0d log_avail", i), {31'd0, log_avail}, {31'd0, vecs[i].exp_avail});
    end

    // Overflow: DEPTH+3 pushes, the last three are dropped
    push_seq(DEPTH + 3);
    chk("ovf log_avail", {31'd0, log_avail}, 32'd1);
    xfer("ovf status", 1'b0, 12'h004, 32'h0, 0, 8'h00, 32'h0400_0006, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      xfer($sformatf("drain%0d", i), 1'b0, 12'h000, 32'h0, 0, 8'h00,
           {23'd0, 1'b1, 8'(i)}, 1'b0);
    chk("drained log_avail", {31'd0, log_avail}, 32'd0);
    xfer("ovf sticky", 1'b0, 12'h004, 32'h0, 0, 8'h00, 32'h0000_0005, 1'b0);

    // Flush coinciding with a push: both lost, overflow untouched
    push_seq(5);
    xfer("count5 status", 1'b0, 12'h004, 32'h0, 0, 8'h00, 32'h0005_0004, 1'b0);
    xfer("flush+push", 1'b1, 12'h008, 32'h1, 3, 8'hEE, 32'h0, 1'b0);
    xfer("after flush", 1'b0, 12'h004, 32'h0, 0, 8'h00, 32'h0000_0005, 1'b0);
    xfer("w1c", 1'b1, 12'h004, 32'h4, 0, 8'h00, 32'h0, 1'b0);
    xfer("after w1c", 1'b0, 12'h004, 32'h0, 0, 8'h00, 32'h0000_0001, 1'b0);

    // Full FIFO, push in the RESP cycle of a DATA read is accepted
    push_seq(DEPTH);
    xfer("full pop+push", 1'b0, 12'h000, 32'h0, 3, 8'hAB, 32'h0000_0100, 1'b0);
    xfer("full status", 1'b0, 12'h004, 32'h0, 0, 8'h00, 32'h0400_0002, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++)
      xfer($sformatf("fdrain%0d", i), 1'b0, 12'h000, 32'h0, 0, 8'h00,
           {23'd0, 1'b1, 8'(i + 1)}, 1'b0);
    xfer("fdrain tail", 1'b0, 12'h000, 32'h0, 0, 8'h00, 32'h0000_01AB, 1'b0);

    // Empty at setup, push lands during the wait state
    xfer("empty setup", 1'b0, 12'h000, 32'h0, 2, 8'h5A, 32'h0, 1'b0);
    xfer("late push status", 1'b0, 12'h004, 32'h0, 0, 8'h00, 32'h0001_0000, 1'b0);
    xfer("late push data", 1'b0, 12'h000, 32'h0, 0, 8'h00, 32'h0000_015A, 1'b0);

    // Reset during the wait state abandons the transfer
    push1(8'h11); push1(8'h22); push1(8'h33);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 12'h000; PWRITE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1; core_rst = 1'b1;
    @(posedge clk); #1;
    core_rst = 1'b0;
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      if (PREADY) highs++;
      @(posedge clk); #1;
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    chk("rst wait pready", 32'(highs), 32'd0);
    chk("rst wait log_avail", {31'd0, log_avail}, 32'd0);
    xfer("rst wait status", 1'b0, 12'h004, 32'h0, 0, 8'h00, 32'h0000_0001, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/log_fifo_apb_reader.md
Name: log_fifo_apb_reader

Overview:
- Drain-side consumer of the firmware log character stream (`fifo_char` / `fifo_write_en`) that the FPGA top taps from generic output wire 0.
- Buffers characters in a synchronous-RAM FIFO.
- Exposes them to the host over an APB slave, so the host pops one character per read of the DATA register.
- Sits in the FPGA shell beside the Caliptra wrapper, on the same APB fabric.

Parameters:
- DEPTH, 1024, FIFO entries (power of two, ≥ 4).
- PTR_W, $clog2(DEPTH), pointer width. Derived; not to be overridden.
- ADDR_W, 12, APB address bits decoded.

Ports:
- core_clk  in  1  sole clock (log source, FIFO and APB all share it).
- core_rst  in  1  synchronous, active-high reset.
- fifo_char  in  8  log character from the writer.
- fifo_write_en  in  1  1-cycle push strobe qualifying fifo_char.
- PADDR  in  ADDR_W  APB address (byte).
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  APB direction.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data.
- PREADY  out  1  APB ready.
- PSLVERR  out  1  APB error.
- log_avail  out  1  level: FIFO not empty (host interrupt/poll).

Behaviour:
- Reset (core_rst=1 at a core_clk edge):
  - rd_ptr, wr_ptr and count = 0.
  - overflow = 0; FSM = IDLE.
  - PRDATA = 0, PREADY = 0, PSLVERR = 0, log_avail = 0.
  - Reset mid-transfer abandons the transfer; the master must restart it.
- Register map, decoded on PADDR[3:2]; PADDR[ADDR_W-1:4] must be 0, otherwise the address is unmapped:
  - 0x0 DATA (RO):
    - [7:0] char at head, [8] valid; pops on read.
    - If empty: [8]=0, [7:0]=0, no pop.
  - 0x4 STATUS:
    - [0] empty, [1] full, [2] overflow (sticky, W1C via PWDATA[2]).
    - [15:3] = 0, [31:16] = count (zero-extended).
  - 0x8 CTRL (WO, reads 0):
    - PWDATA[0]=1 flushes: both pointers and count to 0; overflow unchanged.
  - 0xC: unmapped.
- APB FSM, every transfer takes exactly one wait state:
  - IDLE: on PSEL & !PENABLE (setup), latch address/direction and present rd_ptr to the RAM read port. Next state WAIT.
  - WAIT: PREADY = 0. Next state RESP.
  - RESP: PREADY = 1 for one cycle. PRDATA valid (RAM output registered in WAIT). Side effects (pop, W1C, flush) commit on this edge. Next state IDLE.
  - PRDATA and PSLVERR are 0 whenever PREADY = 0.
- PSLVERR = 1 in RESP for any of:
  - write to DATA;
  - read of CTRL is not an error (returns 0);
  - access to an unmapped address. No side effects.
- Push side:
  - fifo_write_en with count < DEPTH: write RAM[wr_ptr], wr_ptr + 1 (mod DEPTH), count + 1.
  - fifo_write_en with count == DEPTH: char dropped, overflow ← 1. The overflow set wins over a same-cycle W1C.
- Pop:
  - RESP of a DATA read with count > 0: rd_ptr + 1 (mod DEPTH), count − 1.
  - The returned char is the head captured at setup.
  - A push in WAIT/RESP cannot change a head that already existed.
  - If the FIFO was empty at setup, the read returns valid = 0 even if a push lands during WAIT.
- Simultaneous push and pop: both pointers advance, count unchanged. Allowed when full: the push is accepted because a slot frees the same cycle.
- Flush committing in the same cycle as a push: flush wins, the char is discarded, overflow is not set.
- Pointers wrap naturally at DEPTH. count needs PTR_W+1 bits to represent DEPTH.
- log_avail = (count != 0), registered from count.

Test Plan:
- Reset, then STATUS read → PRDATA = 0x0000_0001 (empty), PREADY high on the 3rd cycle after setup, log_avail = 0.
- Push 'H' (0x48) and 'i' (0x69), then read DATA twice → 0x148, then 0x169; a third read → 0x000; STATUS count = 0.
- Push DEPTH+3 chars (0x00..) → STATUS = {count=DEPTH, overflow=1, full=1}. Drain returns 0x00..(DEPTH−1)&0xFF in order; W1C 0x4 clears overflow.
- FIFO full, push coinciding with the RESP cycle of a DATA read → char accepted, count stays DEPTH, overflow stays 0.
- Write 0x1 to CTRL with push on the same commit cycle, count = 5 before → count = 0, empty = 1, overflow unchanged.
- Error cases: write DATA → PSLVERR = 1 and count unchanged; read 0x10 → PSLVERR = 1 and PRDATA = 0; core_rst asserted during WAIT → PREADY never rises, FIFO empty afterwards.
